// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with conditional branches,
// external redirect, flag register and a RUN/DRAIN/HALTED halt FSM.
// Optional feature: define PC_FLAG_BYPASS_EN to let the branch condition
// see flag bits that are being written in the same cycle.
module pc_sequencer #(
    parameter int                ADDR_W       = 16,
    parameter int                OFFSET_W     = 9,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter int                DRAIN_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       instruction,
    input  logic [ADDR_W-1:0] branch_reg_val,
    input  logic [3:0]        flag_wr_op,
    input  logic [2:0]        flags,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus_two,
    output logic              branch_taken,
    output logic [2:0]        flags_q,
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic       HAS_DRAIN  = (DRAIN_CYCLES > 0);
    localparam logic [3:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? 4'(DRAIN_CYCLES - 1) : 4'd0;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [2:0]        flags_d;

    logic [3:0] opcode;
    logic [2:0] cond;
    logic       is_b, is_br, is_hlt;
    logic       in_run;
    logic       upd_nv, upd_z;
    logic [2:0] cond_flags;
    logic       cond_ok;
    logic       b_taken, br_taken;

    logic signed [OFFSET_W:0]   off_sh;
    logic signed [ADDR_W-1:0]   off_ext;
    logic        [ADDR_W-1:0]   b_target;

    logic unused_ok;

    // Condition codes evaluated on {N,Z,V}
    function automatic logic cond_met(input logic [2:0] c, input logic n,
                                      input logic z, input logic v);
        logic r;
        case (c)
            3'b000:  r = ~z;
            3'b001:  r = z;
            3'b010:  r = ~z & ~n;
            3'b011:  r = n;
            3'b100:  r = z | (~z & ~n);
            3'b101:  r = n | z;
            3'b110:  r = v;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    assign opcode = instruction[15:12];
    assign cond   = instruction[11:9];
    assign is_b   = (opcode == 4'hC);
    assign is_br  = (opcode == 4'hD);
    assign is_hlt = (opcode == 4'hF);
    assign in_run = (state_q == ST_RUN);

    // Only the low OFFSET_W immediate bits feed the branch target
    assign unused_ok = &{1'b0, instruction};

    assign pc          = pc_q;
    assign pc_plus_two = pc_q + ADDR_W'(2);
    assign halted      = (state_q == ST_HALTED);

    // Halfword offset, sign-extended (or truncated) to the address width
    assign off_sh   = {instruction[OFFSET_W-1:0], 1'b0};
    assign off_ext  = ADDR_W'(off_sh);
    assign b_target = pc_plus_two + off_ext;

    // Decide which flag bits load this cycle and form the next flag value
    always_comb begin
        upd_nv  = 1'b0;
        upd_z   = 1'b0;
        if (!stall && (state_q != ST_HALTED)) begin
            case (flag_wr_op)
                4'h0, 4'h1: begin
                    upd_nv = 1'b1;
                    upd_z  = 1'b1;
                end
                4'h3, 4'h4, 4'h5, 4'h6: upd_z = 1'b1;
                default: ;
            endcase
        end
        flags_d = flags_q;
        if (upd_nv) begin
            flags_d[2] = flags[2];
            flags_d[0] = flags[0];
        end
        if (upd_z) begin
            flags_d[1] = flags[1];
        end
    end

`ifdef PC_FLAG_BYPASS_EN
    // flags_d already merges freshly written bits with held ones
    assign cond_flags = flags_d;
`else
    assign cond_flags = flags_q;
`endif

    assign cond_ok      = cond_met(cond, cond_flags[2], cond_flags[1], cond_flags[0]);
    assign b_taken      = in_run & ~redirect_valid & is_b & cond_ok;
    assign br_taken     = in_run & ~redirect_valid & is_br & cond_ok;
    assign branch_taken = b_taken | br_taken;

    // Next PC, FSM state and drain counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        case (state_q)
            ST_RUN: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end else if (b_taken) begin
                    pc_d = b_target;
                end else if (br_taken) begin
                    pc_d = branch_reg_val;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (is_hlt) begin
                    pc_d = pc_q;
                    if (HAS_DRAIN) begin
                        state_d = ST_DRAIN;
                        cnt_d   = DRAIN_LOAD;
                    end else begin
                        state_d = ST_HALTED;
                    end
                end else begin
                    pc_d = pc_plus_two;
                end
            end
            ST_DRAIN: begin
                if (redirect_valid) begin
                    state_d = ST_RUN;
                    pc_d    = redirect_pc;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_HALTED;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HALTED: ;
            default: begin
                state_d = ST_RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State, PC and flag registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
            pc_q    <= RESET_PC;
            flags_q <= 3'b000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: a default 16-bit instance
// and an 8-bit instance with DRAIN_CYCLES=0 for wrap and direct-halt cases.
module tb_pc_sequencer;

    int total = 0;
    int bad   = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instruction;
    logic [15:0] branch_reg_val;
    logic [3:0]  flag_wr_op;
    logic [2:0]  flags;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [15:0] pc;
    logic [15:0] pc_plus_two;
    logic        branch_taken;
    logic [2:0]  flags_q;
    logic        halted;

    logic        b_rst;
    logic [15:0] b_instruction;
    logic [7:0]  b_branch_reg_val;
    logic [3:0]  b_flag_wr_op;
    logic [2:0]  b_flags;
    logic        b_stall;
    logic        b_redirect_valid;
    logic [7:0]  b_redirect_pc;
    logic [7:0]  b_pc;
    logic [7:0]  b_pc_plus_two;
    logic        b_branch_taken;
    logic [2:0]  b_flags_q;
    logic        b_halted;

    always #5 clk = ~clk;

    pc_sequencer u_dut (
        .clk(clk), .rst(rst), .instruction(instruction),
        .branch_reg_val(branch_reg_val), .flag_wr_op(flag_wr_op), .flags(flags),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .pc(pc), .pc_plus_two(pc_plus_two), .branch_taken(branch_taken),
        .flags_q(flags_q), .halted(halted)
    );

    pc_sequencer #(.ADDR_W(8), .DRAIN_CYCLES(0)) u_dut8 (
        .clk(clk), .rst(b_rst), .instruction(b_instruction),
        .branch_reg_val(b_branch_reg_val), .flag_wr_op(b_flag_wr_op), .flags(b_flags),
        .stall(b_stall), .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
        .pc(b_pc), .pc_plus_two(b_pc_plus_two), .branch_taken(b_branch_taken),
        .flags_q(b_flags_q), .halted(b_halted)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++; if (pc !== 16'h0000) begin bad++; $display("FAIL rst_pc got=%h want=0000", pc); end
        total++; if (pc_plus_two !== 16'h0002) begin bad++; $display("FAIL rst_pc2 got=%h want=0002", pc_plus_two); end
        total++; if (flags_q !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b want=000", flags_q); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b want=0", halted); end
        rst = 1'b0;
        tick();
        total++; if (pc !== 16'h0002) begin bad++; $display("FAIL step1_pc got=%h want=0002", pc); end
        tick();
        total++; if (pc !== 16'h0004) begin bad++; $display("FAIL step2_pc got=%h want=0004", pc); end
    endtask

    task automatic test_flags();
        flag_wr_op = 4'h0; flags = 3'b111; tick();
        total++; if (flags_q !== 3'b111) begin bad++; $display("FAIL flg_op0 got=%b want=111", flags_q); end
        flag_wr_op = 4'h3; flags = 3'b000; tick();
        total++; if (flags_q !== 3'b101) begin bad++; $display("FAIL flg_op3 got=%b want=101", flags_q); end
        flag_wr_op = 4'h1; flags = 3'b010; tick();
        total++; if (flags_q !== 3'b010) begin bad++; $display("FAIL flg_op1 got=%b want=010", flags_q); end
        stall = 1'b1; flag_wr_op = 4'h0; flags = 3'b111; tick();
        total++; if (flags_q !== 3'b010) begin bad++; $display("FAIL flg_stall got=%b want=010", flags_q); end
        stall = 1'b0; flag_wr_op = 4'h2; flags = 3'b101; tick();
        total++; if (flags_q !== 3'b010) begin bad++; $display("FAIL flg_op2 got=%b want=010", flags_q); end
    endtask

    task automatic test_cond_table();
        logic [2:0] fv [4];
        logic [7:0] mk [4];
        logic [2:0] c;
        fv[0] = 3'b100; mk[0] = 8'b10101001;
        fv[1] = 3'b001; mk[1] = 8'b11010101;
        fv[2] = 3'b010; mk[2] = 8'b10110010;
        fv[3] = 3'b000; mk[3] = 8'b10010101;
        for (int k = 0; k < 4; k++) begin
            instruction = 16'h0000; flag_wr_op = 4'h0; flags = fv[k]; tick();
            flag_wr_op = 4'h2;
            for (int i = 0; i < 8; i++) begin
                c = 3'(i);
                instruction = {4'hC, c, 9'd0};
                #1;
                total++;
                if (branch_taken !== mk[k][i]) begin
                    bad++;
                    $display("FAIL cond flags=%b cond=%0d got=%b want=%b", fv[k], i, branch_taken, mk[k][i]);
                end
            end
        end
        instruction = 16'h0000;
        tick();
    endtask

    task automatic test_branch();
        redirect_valid = 1'b1; redirect_pc = 16'h0010; flag_wr_op = 4'h0; flags = 3'b010; tick();
        redirect_valid = 1'b0; flag_wr_op = 4'h2;
        total++; if (pc !== 16'h0010) begin bad++; $display("FAIL redir_pc got=%h want=0010", pc); end
        instruction = 16'hC3FF; #1;
        total++; if (branch_taken !== 1'b1) begin bad++; $display("FAIL back_taken got=%b want=1", branch_taken); end
        tick();
        total++; if (pc !== 16'h0010) begin bad++; $display("FAIL back_pc got=%h want=0010", pc); end
        instruction = 16'hC005; #1;
        total++; if (branch_taken !== 1'b0) begin bad++; $display("FAIL ne_taken got=%b want=0", branch_taken); end
        tick();
        total++; if (pc !== 16'h0012) begin bad++; $display("FAIL ne_pc got=%h want=0012", pc); end
        instruction = 16'hCE05; tick();
        total++; if (pc !== 16'h001E) begin bad++; $display("FAIL fwd_pc got=%h want=001e", pc); end
        instruction = 16'hDE00; branch_reg_val = 16'h0300; tick();
        total++; if (pc !== 16'h0300) begin bad++; $display("FAIL br_pc got=%h want=0300", pc); end
        instruction = 16'h0000;
    endtask

    task automatic test_bypass();
        logic exp_t;
        logic [15:0] exp_pc;
`ifdef PC_FLAG_BYPASS_EN
        exp_t = 1'b0; exp_pc = 16'h0042;
`else
        exp_t = 1'b1; exp_pc = 16'h004A;
`endif
        redirect_valid = 1'b1; redirect_pc = 16'h0040; flag_wr_op = 4'h0; flags = 3'b000; tick();
        redirect_valid = 1'b0;
        flag_wr_op = 4'h1; flags = 3'b010; instruction = 16'hC004; #1;
        total++; if (branch_taken !== exp_t) begin bad++; $display("FAIL bypass_taken got=%b want=%b", branch_taken, exp_t); end
        tick();
        total++; if (pc !== exp_pc) begin bad++; $display("FAIL bypass_pc got=%h want=%h", pc, exp_pc); end
        total++; if (flags_q !== 3'b010) begin bad++; $display("FAIL bypass_flags got=%b want=010", flags_q); end
        flag_wr_op = 4'h2; instruction = 16'h0000;
    endtask

    task automatic test_stall();
        redirect_valid = 1'b1; redirect_pc = 16'h0050; tick();
        redirect_valid = 1'b0; stall = 1'b1; tick();
        total++; if (pc !== 16'h0050) begin bad++; $display("FAIL stall_pc got=%h want=0050", pc); end
        instruction = 16'hF000; tick();
        stall = 1'b0; instruction = 16'h0000; tick();
        total++; if (pc !== 16'h0052) begin bad++; $display("FAIL stall_hlt_pc got=%h want=0052", pc); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL stall_hlt_halted got=%b want=0", halted); end
    endtask

    task automatic test_halt();
        redirect_valid = 1'b1; redirect_pc = 16'h0020; tick();
        redirect_valid = 1'b0; instruction = 16'hF000; tick();
        total++; if (pc !== 16'h0020) begin bad++; $display("FAIL hlt_acc_pc got=%h want=0020", pc); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL hlt_acc_halted got=%b want=0", halted); end
        instruction = 16'hCE00; flag_wr_op = 4'h0; flags = 3'b101; #1;
        total++; if (branch_taken !== 1'b0) begin bad++; $display("FAIL drain_br got=%b want=0", branch_taken); end
        tick();
        flag_wr_op = 4'h2;
        total++; if (flags_q !== 3'b101) begin bad++; $display("FAIL drain_flags got=%b want=101", flags_q); end
        for (int i = 2; i <= 4; i++) begin
            total++; if (halted !== 1'b0 || pc !== 16'h0020) begin bad++; $display("FAIL drain_hold cyc=%0d halted=%b pc=%h want 0/0020", i - 1, halted, pc); end
            tick();
        end
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_rise got=%b want=1", halted); end
        redirect_valid = 1'b1; redirect_pc = 16'h0100; flag_wr_op = 4'h0; flags = 3'b010; #1;
        total++; if (branch_taken !== 1'b0) begin bad++; $display("FAIL halted_br got=%b want=0", branch_taken); end
        tick();
        total++; if (pc !== 16'h0020) begin bad++; $display("FAIL halted_pc got=%h want=0020", pc); end
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halted_stay got=%b want=1", halted); end
        total++; if (flags_q !== 3'b101) begin bad++; $display("FAIL halted_flags got=%b want=101", flags_q); end
        redirect_valid = 1'b0; flag_wr_op = 4'h2; instruction = 16'h0000;
        #1 rst = 1'b1;
        #1;
        total++; if (pc !== 16'h0000 || halted !== 1'b0) begin bad++; $display("FAIL async_rst_halted pc=%h halted=%b want 0000/0", pc, halted); end
        total++; if (flags_q !== 3'b000) begin bad++; $display("FAIL async_rst_flags got=%b want=000", flags_q); end
        rst = 1'b0;
    endtask

    task automatic test_drain_cancel();
        redirect_valid = 1'b1; redirect_pc = 16'h0020; tick();
        redirect_valid = 1'b0; instruction = 16'hF000; tick();
        instruction = 16'h0000; tick();
        redirect_valid = 1'b1; redirect_pc = 16'h0100; tick();
        total++; if (pc !== 16'h0100) begin bad++; $display("FAIL cancel_pc got=%h want=0100", pc); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL cancel_halted got=%b want=0", halted); end
        redirect_valid = 1'b0; tick();
        total++; if (pc !== 16'h0102) begin bad++; $display("FAIL cancel_run got=%h want=0102", pc); end
        repeat (4) tick();
        total++; if (pc !== 16'h010A || halted !== 1'b0) begin bad++; $display("FAIL cancel_later pc=%h halted=%b want 010a/0", pc, halted); end
        instruction = 16'hF000; tick();
        instruction = 16'h0000; tick();
        total++; if (pc !== 16'h010A) begin bad++; $display("FAIL drain2_pc got=%h want=010a", pc); end
        #1 rst = 1'b1;
        #1;
        total++; if (pc !== 16'h0000) begin bad++; $display("FAIL async_rst_drain got=%h want=0000", pc); end
        rst = 1'b0;
        tick();
        total++; if (pc !== 16'h0002) begin bad++; $display("FAIL post_rst_run got=%h want=0002", pc); end
    endtask

    task automatic test_wrap();
        b_rst = 1'b0; tick();
        total++; if (b_pc !== 8'h02) begin bad++; $display("FAIL w_first got=%h want=02", b_pc); end
        b_redirect_valid = 1'b1; b_redirect_pc = 8'hFE; tick();
        b_redirect_valid = 1'b0; #1;
        total++; if (b_pc_plus_two !== 8'h00) begin bad++; $display("FAIL w_pc2 got=%h want=00", b_pc_plus_two); end
        tick();
        total++; if (b_pc !== 8'h00) begin bad++; $display("FAIL w_seq got=%h want=00", b_pc); end
        b_instruction = 16'hDE00; b_branch_reg_val = 8'hA5; b_stall = 1'b1; #1;
        total++; if (b_branch_taken !== 1'b1) begin bad++; $display("FAIL w_br_taken got=%b want=1", b_branch_taken); end
        tick();
        total++; if (b_pc !== 8'hA5) begin bad++; $display("FAIL w_br_stall got=%h want=a5", b_pc); end
        b_stall = 1'b0; b_instruction = 16'hCE05; b_redirect_valid = 1'b1; b_redirect_pc = 8'h33; #1;
        total++; if (b_branch_taken !== 1'b0) begin bad++; $display("FAIL w_redir_br got=%b want=0", b_branch_taken); end
        tick();
        total++; if (b_pc !== 8'h33) begin bad++; $display("FAIL w_redir_pc got=%h want=33", b_pc); end
        b_redirect_valid = 1'b0; b_instruction = 16'hCE7E; tick();
        total++; if (b_pc !== 8'h31) begin bad++; $display("FAIL w_bwrap got=%h want=31", b_pc); end
        b_instruction = 16'hF000; tick();
        total++; if (b_halted !== 1'b1 || b_pc !== 8'h31) begin bad++; $display("FAIL w_direct_halt halted=%b pc=%h want 1/31", b_halted, b_pc); end
        b_instruction = 16'h0000; tick();
        total++; if (b_pc !== 8'h31) begin bad++; $display("FAIL w_halt_hold got=%h want=31", b_pc); end
    endtask

    initial begin
        rst = 1'b1; instruction = 16'h0000; branch_reg_val = 16'h0000;
        flag_wr_op = 4'h2; flags = 3'b000; stall = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 16'h0000;
        b_rst = 1'b1; b_instruction = 16'h0000; b_branch_reg_val = 8'h00;
        b_flag_wr_op = 4'h0; b_flags = 3'b000; b_stall = 1'b0;
        b_redirect_valid = 1'b0; b_redirect_pc = 8'h00;
        test_reset();
        test_flags();
        test_cond_table();
        test_branch();
        test_bypass();
        test_stall();
        test_halt();
        test_drain_cancel();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
